// File: rtl/ea_sequencer.sv
// Addressing-mode sequencer for the 6502 core: issues operand/pointer/data reads and returns EA, operand, length.
// Build option: define JMP_PAGE_BUG_EN to reproduce the NMOS JMP (indirect) page-wrap on the pointer high byte.
module ea_sequencer #(
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [5:0] mode,
    input  logic       need_data,
    input  logic [8:0] pc,
    input  logic [7:0] x,
    input  logic [7:0] y,
    output logic [8:0] mem_addr,
    output logic       mem_rd,
    input  logic [7:0] mem_rdata,
    output logic       busy,
    output logic       done,
    output logic [8:0] ea,
    output logic [7:0] operand,
    output logic [1:0] bytes,
    output logic       err
);

    typedef enum logic [5:0] {
        M_ACC  = 6'd0,
        M_IMM  = 6'd1,
        M_ZP   = 6'd2,
        M_ZPX  = 6'd3,
        M_ZPY  = 6'd4,
        M_ABS  = 6'd5,
        M_ABSX = 6'd6,
        M_ABSY = 6'd7,
        M_IXID = 6'd8,
        M_IDIX = 6'd9,
        M_INDY = 6'd10,
        M_UNKN = 6'd63
    } addmod_t;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CALC, S_DONE} state_t;

    localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

    state_t     state, state_nxt;
    addmod_t    mode_r, mode_nxt;
    logic       need_r, need_nxt;
    logic [8:0] pc_r, pc_nxt;
    logic [7:0] x_r, x_nxt, y_r, y_nxt;
    logic [7:0] zp_r, zp_nxt, lo_r, lo_nxt;
    logic [1:0] rd_idx, rd_idx_nxt, lat_cnt, lat_cnt_nxt;
    logic [8:0] mem_addr_nxt, ea_nxt;
    logic [7:0] operand_nxt;
    logic [1:0] bytes_nxt;
    logic       err_nxt;
    logic       data_step;

    logic [7:0] zp_index, abs_index, zp_sum, zp_inc;
    logic [8:0] abs_sum, ptr_hi;

    assign zp_index  = (mode_r == M_ZPX || mode_r == M_IXID) ? x_r :
                       (mode_r == M_ZPY) ? y_r : 8'd0;
    assign abs_index = (mode_r == M_ABSX) ? x_r :
                       (mode_r == M_ABSY || mode_r == M_IDIX) ? y_r : 8'd0;
    assign zp_sum    = mem_rdata + zp_index;
    assign zp_inc    = zp_r + 8'd1;
    assign abs_sum   = {mem_rdata[0], lo_r} + {1'b0, abs_index};

    // ea holds the indirect pointer while INDY fetches its target
`ifdef JMP_PAGE_BUG_EN
    assign ptr_hi = {ea[8], ea[7:0] + 8'd1};
`else
    assign ptr_hi = ea + 9'd1;
`endif

    assign mem_rd = (state == S_ISSUE);
    assign busy   = (state != S_IDLE);
    assign done   = (state == S_DONE);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            mode_r   <= M_ACC;
            need_r   <= 1'b0;
            pc_r     <= '0;
            x_r      <= '0;
            y_r      <= '0;
            zp_r     <= '0;
            lo_r     <= '0;
            rd_idx   <= '0;
            lat_cnt  <= '0;
            mem_addr <= '0;
            ea       <= '0;
            operand  <= '0;
            bytes    <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            mode_r   <= mode_nxt;
            need_r   <= need_nxt;
            pc_r     <= pc_nxt;
            x_r      <= x_nxt;
            y_r      <= y_nxt;
            zp_r     <= zp_nxt;
            lo_r     <= lo_nxt;
            rd_idx   <= rd_idx_nxt;
            lat_cnt  <= lat_cnt_nxt;
            mem_addr <= mem_addr_nxt;
            ea       <= ea_nxt;
            operand  <= operand_nxt;
            bytes    <= bytes_nxt;
            err      <= err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        mode_nxt     = mode_r;
        need_nxt     = need_r;
        pc_nxt       = pc_r;
        x_nxt        = x_r;
        y_nxt        = y_r;
        zp_nxt       = zp_r;
        lo_nxt       = lo_r;
        rd_idx_nxt   = rd_idx;
        lat_cnt_nxt  = lat_cnt;
        mem_addr_nxt = mem_addr;
        ea_nxt       = ea;
        operand_nxt  = operand;
        bytes_nxt    = bytes;
        err_nxt      = err;
        data_step    = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    mode_nxt    = addmod_t'(mode);
                    need_nxt    = need_data;
                    pc_nxt      = pc;
                    x_nxt       = x;
                    y_nxt       = y;
                    rd_idx_nxt  = 2'd0;
                    ea_nxt      = '0;
                    operand_nxt = '0;
                    bytes_nxt   = 2'd0;
                    err_nxt     = 1'b0;
                    state_nxt   = S_DONE;
                    case (addmod_t'(mode))
                        M_IMM, M_ZP, M_ZPX, M_ZPY, M_IXID, M_IDIX: begin
                            bytes_nxt    = 2'd1;
                            mem_addr_nxt = pc;
                            state_nxt    = S_ISSUE;
                        end
                        M_ABS, M_ABSX, M_ABSY, M_INDY: begin
                            bytes_nxt    = 2'd2;
                            mem_addr_nxt = pc;
                            state_nxt    = S_ISSUE;
                        end
                        M_ACC:   state_nxt = S_DONE;
                        default: err_nxt   = 1'b1;
                    endcase
                end
            end

            S_ISSUE: begin
                lat_cnt_nxt = 2'd0;
                state_nxt   = S_WAIT;
            end

            // Last wait cycle captures the byte and picks the next address in the same cycle
            S_WAIT: begin
                if (lat_cnt != LAT_LAST) begin
                    lat_cnt_nxt = lat_cnt + 2'd1;
                end else begin
                    rd_idx_nxt = rd_idx + 2'd1;
                    state_nxt  = S_DONE;
                    case (mode_r)
                        M_IMM: begin
                            operand_nxt = mem_rdata;
                            ea_nxt      = pc_r;
                        end
                        M_ZP, M_ZPX, M_ZPY: begin
                            if (rd_idx == 2'd0) begin
                                ea_nxt    = {1'b0, zp_sum};
                                data_step = 1'b1;
                            end else begin
                                operand_nxt = mem_rdata;
                            end
                        end
                        M_ABS, M_ABSX, M_ABSY: begin
                            case (rd_idx)
                                2'd0: begin
                                    lo_nxt       = mem_rdata;
                                    mem_addr_nxt = pc_r + 9'd1;
                                    state_nxt    = S_ISSUE;
                                end
                                2'd1: begin
                                    ea_nxt    = abs_sum;
                                    data_step = 1'b1;
                                end
                                default: operand_nxt = mem_rdata;
                            endcase
                        end
                        M_IXID, M_IDIX: begin
                            case (rd_idx)
                                2'd0: begin
                                    zp_nxt       = (mode_r == M_IXID) ? zp_sum : mem_rdata;
                                    mem_addr_nxt = {1'b0, (mode_r == M_IXID) ? zp_sum : mem_rdata};
                                    state_nxt    = S_ISSUE;
                                end
                                2'd1: begin
                                    lo_nxt       = mem_rdata;
                                    mem_addr_nxt = {1'b0, zp_inc};
                                    state_nxt    = S_ISSUE;
                                end
                                2'd2: begin
                                    ea_nxt    = abs_sum;
                                    data_step = 1'b1;
                                end
                                default: operand_nxt = mem_rdata;
                            endcase
                        end
                        M_INDY: begin
                            case (rd_idx)
                                2'd0: begin
                                    lo_nxt       = mem_rdata;
                                    mem_addr_nxt = pc_r + 9'd1;
                                    state_nxt    = S_ISSUE;
                                end
                                2'd1: begin
                                    ea_nxt       = {mem_rdata[0], lo_r};
                                    mem_addr_nxt = {mem_rdata[0], lo_r};
                                    state_nxt    = S_ISSUE;
                                end
                                2'd2: begin
                                    lo_nxt       = mem_rdata;
                                    mem_addr_nxt = ptr_hi;
                                    state_nxt    = S_ISSUE;
                                end
                                default: ea_nxt = {mem_rdata[0], lo_r};
                            endcase
                        end
                        default: state_nxt = S_DONE;
                    endcase
                end
            end

            S_CALC:  state_nxt = S_IDLE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        if (data_step && need_r) begin
            mem_addr_nxt = ea_nxt;
            state_nxt    = S_ISSUE;
        end
    end

endmodule

// File: tb/tb_ea_sequencer.sv
// Scoreboard bench for ea_sequencer: two instances (MEM_LAT 1 and 3) share stimulus and a 512-byte memory model.
module tb_ea_sequencer;

    localparam logic [5:0] M_ACC  = 6'd0;
    localparam logic [5:0] M_IMM  = 6'd1;
    localparam logic [5:0] M_ZPX  = 6'd3;
    localparam logic [5:0] M_ZPY  = 6'd4;
    localparam logic [5:0] M_ABS  = 6'd5;
    localparam logic [5:0] M_ABSX = 6'd6;
    localparam logic [5:0] M_ABSY = 6'd7;
    localparam logic [5:0] M_IXID = 6'd8;
    localparam logic [5:0] M_IDIX = 6'd9;
    localparam logic [5:0] M_INDY = 6'd10;
    localparam logic [5:0] M_UNKN = 6'd63;

    typedef struct {
        logic [8:0] ea;
        logic [7:0] op;
        logic [1:0] nb;
        logic       err;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, need_data;
    logic [5:0] mode;
    logic [8:0] pc;
    logic [7:0] x, y;

    logic [8:0] mem_addr_1, ea_1, mem_addr_3, ea_3;
    logic       mem_rd_1, busy_1, done_1, err_1, mem_rd_3, busy_3, done_3, err_3;
    logic [7:0] mem_rdata_1, operand_1, mem_rdata_3, operand_3;
    logic [1:0] bytes_1, bytes_3;

    logic [7:0] mem [512];
    logic [7:0] pipe_3 [3];

    int   cyc = 0, start_cyc = 0, checks = 0, errors = 0;
    bit   mon_en = 1'b0;
    exp_t exp_q1[$], exp_q3[$];
    logic [8:0] addr_q1[$], addr_q3[$];

    ea_sequencer #(.MEM_LAT(1)) u_dut_1 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .need_data(need_data),
        .pc(pc), .x(x), .y(y), .mem_addr(mem_addr_1), .mem_rd(mem_rd_1),
        .mem_rdata(mem_rdata_1), .busy(busy_1), .done(done_1), .ea(ea_1),
        .operand(operand_1), .bytes(bytes_1), .err(err_1)
    );

    ea_sequencer #(.MEM_LAT(3)) u_dut_3 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .need_data(need_data),
        .pc(pc), .x(x), .y(y), .mem_addr(mem_addr_3), .mem_rd(mem_rd_3),
        .mem_rdata(mem_rdata_3), .busy(busy_3), .done(done_3), .ea(ea_3),
        .operand(operand_3), .bytes(bytes_3), .err(err_3)
    );

    // Memory model: data appears MEM_LAT cycles after the strobe, garbage otherwise
    always @(posedge clk) begin
        cyc         <= cyc + 1;
        mem_rdata_1 <= (mem_rd_1 === 1'b1) ? mem[mem_addr_1] : 8'hEE;
        pipe_3[0]   <= (mem_rd_3 === 1'b1) ? mem[mem_addr_3] : 8'hEE;
        pipe_3[1]   <= pipe_3[0];
        pipe_3[2]   <= pipe_3[1];
    end
    assign mem_rdata_3 = pipe_3[2];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_done(input string tag, input exp_t e, input logic [8:0] a_ea,
                              input logic [7:0] a_op, input logic [1:0] a_nb,
                              input logic a_err, input logic a_busy);
        check_output({"ea", tag}, a_ea, e.ea);
        check_output({"operand", tag}, a_op, e.op);
        check_output({"bytes", tag}, a_nb, e.nb);
        check_output({"err", tag}, a_err, e.err);
        check_output({"busy_at_done", tag}, a_busy, 1);
        check_output({"latency", tag}, cyc - start_cyc, e.lat);
    endtask

    task automatic check_all_zero();
        check_output("zero_mem_addr_1", mem_addr_1, 0);
        check_output("zero_mem_rd_1", mem_rd_1, 0);
        check_output("zero_busy_1", busy_1, 0);
        check_output("zero_done_1", done_1, 0);
        check_output("zero_ea_1", ea_1, 0);
        check_output("zero_operand_1", operand_1, 0);
        check_output("zero_bytes_1", bytes_1, 0);
        check_output("zero_err_1", err_1, 0);
        check_output("zero_mem_addr_3", mem_addr_3, 0);
        check_output("zero_mem_rd_3", mem_rd_3, 0);
        check_output("zero_busy_3", busy_3, 0);
        check_output("zero_done_3", done_3, 0);
        check_output("zero_ea_3", ea_3, 0);
        check_output("zero_operand_3", operand_3, 0);
        check_output("zero_bytes_3", bytes_3, 0);
        check_output("zero_err_3", err_3, 0);
    endtask

    // Monitor: every read strobe and done pulse is matched against the scoreboard queues
    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_rd_1 === 1'b1) begin
                if (addr_q1.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL rd_addr_1: unexpected read at 0x%0h, expected none", mem_addr_1);
                end else check_output("rd_addr_1", mem_addr_1, addr_q1.pop_front());
            end
            if (mem_rd_3 === 1'b1) begin
                if (addr_q3.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL rd_addr_3: unexpected read at 0x%0h, expected none", mem_addr_3);
                end else check_output("rd_addr_3", mem_addr_3, addr_q3.pop_front());
            end
            if (done_1 === 1'b1) begin
                if (exp_q1.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL done_1: unexpected done pulse, expected none (cycle %0d)", cyc);
                end else check_done("_1", exp_q1.pop_front(), ea_1, operand_1, bytes_1, err_1, busy_1);
            end
            if (done_3 === 1'b1) begin
                if (exp_q3.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL done_3: unexpected done pulse, expected none (cycle %0d)", cyc);
                end else check_done("_3", exp_q3.pop_front(), ea_3, operand_3, bytes_3, err_3, busy_3);
            end
        end
    end

    // poke > 0 raises start again that many cycles after the accepted start
    task automatic apply_stimulus(input logic [5:0] m, input logic nd, input logic [8:0] p,
                                  input logic [7:0] xi, input logic [7:0] yi, input int n,
                                  input logic [8:0] a0, input logic [8:0] a1,
                                  input logic [8:0] a2, input logic [8:0] a3,
                                  input logic [8:0] e_ea, input logic [7:0] e_op,
                                  input logic [1:0] e_nb, input logic e_err, input int poke);
        logic [8:0] al [4];
        exp_t e;
        al = '{a0, a1, a2, a3};
        for (int i = 0; i < n; i++) begin
            addr_q1.push_back(al[i]);
            addr_q3.push_back(al[i]);
        end
        e.ea = e_ea; e.op = e_op; e.nb = e_nb; e.err = e_err;
        e.lat = n * 2 + 1;
        exp_q1.push_back(e);
        e.lat = n * 4 + 1;
        exp_q3.push_back(e);
        @(negedge clk);
        start = 1'b1; mode = m; need_data = nd; pc = p; x = xi; y = yi;
        start_cyc = cyc;
        for (int i = 1; i <= 60 && (exp_q1.size() != 0 || exp_q3.size() != 0); i++) begin
            @(negedge clk);
            start = (i == poke);
        end
        start = 1'b0;
        if (exp_q1.size() != 0 || exp_q3.size() != 0) begin
            checks++; errors++;
            $display("[TB] FAIL timeout: done not seen for mode %0d, expected within 60 cycles", m);
            exp_q1.delete(); exp_q3.delete(); addr_q1.delete(); addr_q3.delete();
        end
        @(negedge clk);
        check_output("hold_ea_1", ea_1, e_ea);
        check_output("hold_ea_3", ea_3, e_ea);
        check_output("idle_busy_1", busy_1, 0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        rst_n = 1'b0; start = 1'b0; mode = M_ACC; need_data = 1'b0;
        pc = '0; x = '0; y = '0;
        repeat (3) @(negedge clk);
        check_all_zero();
        rst_n = 1'b1;
        mon_en = 1'b1;

        mem[9'h010] = 8'h42;
        apply_stimulus(M_IMM, 1'b0, 9'h010, 8'h00, 8'h00, 1, 9'h010, 0, 0, 0, 9'h010, 8'h42, 2'd1, 1'b0, 0);

        mem[9'h020] = 8'hF0; mem[9'h010] = 8'h5A;
        apply_stimulus(M_ZPX, 1'b1, 9'h020, 8'h20, 8'h00, 2, 9'h020, 9'h010, 0, 0, 9'h010, 8'h5A, 2'd1, 1'b0, 2);

        mem[9'h030] = 8'hFF; mem[9'h031] = 8'h01; mem[9'h001] = 8'hAB;
        apply_stimulus(M_ABSY, 1'b0, 9'h030, 8'h00, 8'h02, 2, 9'h030, 9'h031, 0, 0, 9'h001, 8'h00, 2'd2, 1'b0, 5);

        mem[9'h040] = 8'hFE; mem[9'h0FF] = 8'h34; mem[9'h000] = 8'h01; mem[9'h134] = 8'h77;
        apply_stimulus(M_IXID, 1'b1, 9'h040, 8'h01, 8'h00, 4, 9'h040, 9'h0FF, 9'h000, 9'h134, 9'h134, 8'h77, 2'd1, 1'b0, 0);

        mem[9'h050] = 8'hFF; mem[9'h051] = 8'h00; mem[9'h0FF] = 8'h80; mem[9'h100] = 8'h01; mem[9'h000] = 8'h00;
`ifdef JMP_PAGE_BUG_EN
        apply_stimulus(M_INDY, 1'b1, 9'h050, 8'h00, 8'h00, 4, 9'h050, 9'h051, 9'h0FF, 9'h000, 9'h080, 8'h00, 2'd2, 1'b0, 0);
`else
        apply_stimulus(M_INDY, 1'b1, 9'h050, 8'h00, 8'h00, 4, 9'h050, 9'h051, 9'h0FF, 9'h100, 9'h180, 8'h00, 2'd2, 1'b0, 0);
`endif

        apply_stimulus(M_UNKN, 1'b1, 9'h1AB, 8'h11, 8'h22, 0, 0, 0, 0, 0, 9'h000, 8'h00, 2'd0, 1'b1, 0);
        apply_stimulus(M_ACC, 1'b1, 9'h1AB, 8'h11, 8'h22, 0, 0, 0, 0, 0, 9'h000, 8'h00, 2'd0, 1'b0, 0);

        mem[9'h070] = 8'h80; mem[9'h080] = 8'hF0; mem[9'h081] = 8'h01; mem[9'h010] = 8'h99;
        apply_stimulus(M_IDIX, 1'b1, 9'h070, 8'h55, 8'h20, 4, 9'h070, 9'h080, 9'h081, 9'h010, 9'h010, 8'h99, 2'd1, 1'b0, 0);

        mem[9'h1FF] = 8'hF0; mem[9'h000] = 8'h00; mem[9'h110] = 8'h3C;
        apply_stimulus(M_ABSX, 1'b1, 9'h1FF, 8'h20, 8'h00, 3, 9'h1FF, 9'h000, 9'h110, 0, 9'h110, 8'h3C, 2'd2, 1'b0, 0);

        mem[9'h0A0] = 8'h10; mem[9'h015] = 8'h66;
        apply_stimulus(M_ZPY, 1'b1, 9'h0A0, 8'h09, 8'h05, 2, 9'h0A0, 9'h015, 0, 0, 9'h015, 8'h66, 2'd1, 1'b0, 0);

        // Reset in cycle 3 of an ABS sequence: reads already issued are expected, no done
        addr_q1.push_back(9'h060); addr_q1.push_back(9'h061);
        addr_q3.push_back(9'h060);
        @(negedge clk);
        start = 1'b1; mode = M_ABS; need_data = 1'b1; pc = 9'h060; x = '0; y = '0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero();
        rst_n = 1'b1;
        check_output("rst_reads_left_1", addr_q1.size(), 0);
        check_output("rst_reads_left_3", addr_q3.size(), 0);
        addr_q1.delete(); addr_q3.delete();

        mem[9'h011] = 8'hC3;
        apply_stimulus(M_IMM, 1'b1, 9'h011, 8'h00, 8'h00, 1, 9'h011, 0, 0, 0, 9'h011, 8'hC3, 2'd1, 1'b0, 0);

        repeat (10) @(negedge clk);
        check_output("leftover_exp", exp_q1.size() + exp_q3.size(), 0);
        check_output("leftover_reads", addr_q1.size() + addr_q3.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
